abc_vector_checker: RTL and testbench

Built-in self-test sequencer for the 3-input `abc` logic cell (y = a·b + ¬b·c). On `start` it drives all eight {a,b,c} input vectors into a connected cell and waits a programmable settle time. It then samples `y`, compares it against an expected truth table, and reports per-vector failures, an error count and pass/fail. It sits at the stimulus/checker end of the cell's interface and replaces the software bench on silicon and FPGA builds.

---
 rtl/abc_check_pkg.sv | 21 ++
 rtl/abc_settle_timer.sv | 29 ++
 rtl/abc_vector_checker.sv | 128 ++++++++++++
 tb/tb_abc_vector_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/abc_check_pkg.sv
// Shared types and constants for the abc cell self-test sequencer.
package abc_check_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // One vector per combination of the three cell inputs.
  localparam int NUM_VECTORS = 8;

  // Truth table of y = a&b | ~b&c, bit i for {a,b,c} = i.
  localparam logic [NUM_VECTORS-1:0] ABC_EXPECTED = 8'hE2;

  // Width of the settle counter; holds settle times up to 15.
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/abc_settle_timer.sv
// Loadable down-counter that measures how long a vector is held
// before the cell response is trusted.
module abc_settle_timer
  import abc_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  logic [SETTLE_W-1:0] count;

  // Load on entry to the settle phase, then count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= SETTLE_W'(SETTLE_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/abc_vector_checker.sv
// Built-in self-test sequencer: sweeps all eight {a,b,c} vectors into
// the abc cell, samples y after a settle time and records failures.
module abc_vector_checker
  import abc_check_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = ABC_EXPECTED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  input  logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [3:0]             error_count,
  output logic [NUM_VECTORS-1:0] fail_mask
);

  state_t                   state, state_n;
  logic [2:0]               idx, idx_n;
  logic [2:0]               abc, abc_n;
  logic                     busy_n, done_n, pass_n;
  logic [3:0]               count_n;
  logic [NUM_VECTORS-1:0]   mask_n;
  logic                     load;
  logic                     expire;
  logic                     mismatch;

  abc_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .expire (expire)
  );

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-result logic; X/Z on y never equals a 0/1 table bit.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    abc_n    = abc;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    count_n  = error_count;
    mask_n   = fail_mask;
    load     = 1'b0;
    mismatch = (y !== EXPECTED[idx]);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SETTLE;
          idx_n   = '0;
          abc_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          count_n = '0;
          mask_n  = '0;
          load    = 1'b1;
        end
      end
      SETTLE: begin
        if (expire) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          mask_n[idx] = 1'b1;
          count_n     = error_count + 4'd1;
        end
        if (idx == 3'(NUM_VECTORS - 1)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (count_n == '0);
        end else begin
          state_n = SETTLE;
          idx_n   = idx + 3'd1;
          abc_n   = idx + 3'd1;
          load    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs and sweep bookkeeping, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      abc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
      fail_mask   <= '0;
    end else begin
      idx         <= idx_n;
      abc         <= abc_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      error_count <= count_n;
      fail_mask   <= mask_n;
    end
  end

  assign {a, b, c} = abc;

endmodule

// File: tb/tb_abc_vector_checker.sv
// Self-checking bench for abc_vector_checker: three instances (default,
// one-cycle settle, inverted table) driven by a selectable cell model.
module tb_abc_vector_checker;

  localparam int MODE_CORRECT = 0;
  localparam int MODE_ZERO    = 1;
  localparam int MODE_INV     = 2;
  localparam int MODE_RAND    = 3;
  localparam int MODE_PIPE    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v;
  wire  [2:0] y_v;
  logic [3:0] ec_v [3];
  logic [7:0] mask_v [3];
  logic [2:0] p1 = '0;
  logic [2:0] p2 = '0;
  int         mode = MODE_CORRECT;
  logic [7:0] rnd = '0;
  int         checks = 0;
  int         errors = 0;

  int         settle_of [3] = '{2, 1, 2};
  logic [7:0] table_of  [3] = '{8'hE2, 8'hE2, 8'h1D};

  always #5 clk = ~clk;

  // The cell as a boolean equation.
  function automatic logic cell_f(input logic [2:0] v);
    return (v[2] & v[1]) | (~v[1] & v[0]);
  endfunction

  function automatic logic respond(input int m, input logic [2:0] v,
                                   input logic [7:0] r, input logic piped);
    case (m)
      MODE_CORRECT: return cell_f(v);
      MODE_ZERO:    return 1'b0;
      MODE_INV:     return ~cell_f(v);
      MODE_RAND:    return r[v];
      default:      return piped;
    endcase
  endfunction

  // Two output register stages behind the cell, one pipe per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p1[i] <= cell_f({a_v[i], b_v[i], c_v[i]});
      p2[i] <= p1[i];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_cell
    assign y_v[g] = respond(mode, {a_v[g], b_v[g], c_v[g]}, rnd, p2[g]);
  end

  abc_vector_checker #(.SETTLE_CYCLES(2), .EXPECTED(8'hE2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .error_count(ec_v[0]), .fail_mask(mask_v[0])
  );

  abc_vector_checker #(.SETTLE_CYCLES(1), .EXPECTED(8'hE2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .error_count(ec_v[1]), .fail_mask(mask_v[1])
  );

  abc_vector_checker #(.SETTLE_CYCLES(2), .EXPECTED(8'h1D)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .error_count(ec_v[2]), .fail_mask(mask_v[2])
  );

  // Reference: what the cell returns for each vector at sampling time,
  // compared against the instance's table.
  task automatic model_sweep(input int inst, output logic [7:0] m,
                             output logic [3:0] cnt);
    logic obs;
    m   = '0;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        MODE_CORRECT: obs = cell_f(3'(i));
        MODE_ZERO:    obs = 1'b0;
        MODE_INV:     obs = ~cell_f(3'(i));
        MODE_RAND:    obs = rnd[i];
        default:      obs = (settle_of[inst] >= 2) ? cell_f(3'(i))
                                                   : cell_f(3'((i == 0) ? 0 : i - 1));
      endcase
      m[i] = obs ^ table_of[inst][i];
      if (m[i]) cnt = cnt + 4'd1;
    end
  endtask

  // Pulse start, optionally re-pulse mid-sweep, wait for done and check results.
  task automatic run_sweep(input int inst, input bit repulse, input bit abc_check);
    logic [7:0] exp_mask;
    logic [3:0] exp_cnt;
    int         per;
    int         t;
    bit         seen;
    per = settle_of[inst] + 1;
    model_sweep(inst, exp_mask, exp_cnt);
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[inst] = 1'b0;
    checks++; if (busy_v[inst] !== 1'b1) begin errors++; $display("[TB] FAIL start_busy inst%0d: got %0b want 1", inst, busy_v[inst]); end
    checks++; if (done_v[inst] !== 1'b0) begin errors++; $display("[TB] FAIL start_done inst%0d: got %0b want 0", inst, done_v[inst]); end
    checks++; if (pass_v[inst] !== 1'b0) begin errors++; $display("[TB] FAIL start_pass inst%0d: got %0b want 0", inst, pass_v[inst]); end
    checks++; if (ec_v[inst] !== 4'd0) begin errors++; $display("[TB] FAIL start_count inst%0d: got %0d want 0", inst, ec_v[inst]); end
    checks++; if (mask_v[inst] !== 8'h00) begin errors++; $display("[TB] FAIL start_mask inst%0d: got %h want 00", inst, mask_v[inst]); end
    t = 0;
    seen = 1'b0;
    while (!seen && t < 200) begin
      if (abc_check && t < 8 * per) begin
        checks++;
        if ({a_v[inst], b_v[inst], c_v[inst]} !== 3'(t / per) || busy_v[inst] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL vector_drive t=%0d: got abc=%b busy=%b want abc=%b busy=1",
                   t, {a_v[inst], b_v[inst], c_v[inst]}, busy_v[inst], 3'(t / per));
        end
      end
      if (done_v[inst] === 1'b1) begin
        seen = 1'b1;
      end else begin
        start_v[inst] = repulse && (t == 4 || t == 9);
        @(posedge clk);
        @(negedge clk);
        t++;
      end
    end
    start_v[inst] = 1'b0;
    checks++; if (!seen || t != 8 * per) begin errors++; $display("[TB] FAIL done_time inst%0d: got %0d cycles (seen=%0b) want %0d", inst, t, seen, 8 * per); end
    checks++; if (ec_v[inst] !== exp_cnt) begin errors++; $display("[TB] FAIL error_count inst%0d: got %0d want %0d", inst, ec_v[inst], exp_cnt); end
    checks++; if (mask_v[inst] !== exp_mask) begin errors++; $display("[TB] FAIL fail_mask inst%0d: got %h want %h", inst, mask_v[inst], exp_mask); end
    checks++; if (pass_v[inst] !== (exp_cnt == 4'd0)) begin errors++; $display("[TB] FAIL pass inst%0d: got %0b want %0b", inst, pass_v[inst], exp_cnt == 4'd0); end
    checks++; if (busy_v[inst] !== 1'b0) begin errors++; $display("[TB] FAIL end_busy inst%0d: got %0b want 0", inst, busy_v[inst]); end
    checks++; if ({a_v[inst], b_v[inst], c_v[inst]} !== 3'b111) begin errors++; $display("[TB] FAIL end_vector inst%0d: got %b want 111", inst, {a_v[inst], b_v[inst], c_v[inst]}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_v[i], b_v[i], c_v[i], busy_v[i], done_v[i], pass_v[i]} !== 6'b0 ||
          ec_v[i] !== 4'd0 || mask_v[i] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_outputs inst%0d: got abc=%b busy=%b done=%b pass=%b cnt=%0d mask=%h want all 0",
                 i, {a_v[i], b_v[i], c_v[i]}, busy_v[i], done_v[i], pass_v[i], ec_v[i], mask_v[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_correct_cell();
    mode = MODE_CORRECT;
    run_sweep(0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL done_hold: got done=%b pass=%b want 1 1", done_v[0], pass_v[0]); end
  endtask

  task automatic test_faulty_cells();
    mode = MODE_ZERO;
    run_sweep(0, 1'b0, 1'b0);
    mode = MODE_INV;
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic test_random_cells();
    for (int n = 0; n < 6; n++) begin
      mode = MODE_RAND;
      rnd  = 8'($urandom);
      run_sweep(int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_pipelined_cell();
    mode = MODE_PIPE;
    run_sweep(1, 1'b0, 1'b1);
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    mode = MODE_CORRECT;
    run_sweep(0, 1'b1, 1'b1);
    mode = MODE_ZERO;
    run_sweep(0, 1'b0, 1'b0);
    mode = MODE_CORRECT;
    run_sweep(0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    mode = MODE_CORRECT;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++; if ({a_v[0], b_v[0], c_v[0]} !== 3'b011) begin errors++; $display("[TB] FAIL abort_vector: got %b want 011", {a_v[0], b_v[0], c_v[0]}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0]} !== 6'b0 ||
        ec_v[0] !== 4'd0 || mask_v[0] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got abc=%b busy=%b done=%b pass=%b cnt=%0d mask=%h want all 0",
               {a_v[0], b_v[0], c_v[0]}, busy_v[0], done_v[0], pass_v[0], ec_v[0], mask_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1'b0, 1'b1);
  endtask

  task automatic test_table_param();
    mode = MODE_CORRECT;
    run_sweep(2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_correct_cell();
    test_faulty_cells();
    test_pipelined_cell();
    test_back_to_back();
    test_abort();
    test_table_param();
    test_random_cells();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung sweep.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
